// File: rtl/square_wave_period_meter.sv
// Square-wave period/high-time meter: Schmitt front end, edge counter,
// pending snapshot and a bit-serial restoring divider for frequency.
module square_wave_period_meter #(
  parameter int unsigned        CLOCK_RATE     = 50000000,
  parameter logic signed [15:0] TH_HIGH        = 16'sd10923,
  parameter logic signed [15:0] TH_LOW         = 16'sd5461,
  parameter int unsigned        TIMEOUT_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic signed [15:0] in_wave,
  output logic [31:0]        period_cycles,
  output logic [31:0]        high_cycles,
  output logic [15:0]        freq_hz,
  output logic               valid,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        level_q, level_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hcap_q, hcap_d;
  logic        fell_q, fell_d;
  logic        armed_q, armed_d;
  logic        tmo_q, tmo_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_p_q, pend_p_d;
  logic [31:0] pend_h_q, pend_h_d;
  logic [31:0] div_q, div_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] hact_q, hact_d;
  logic        disc_q, disc_d;
  logic [31:0] per_q, per_d;
  logic [31:0] hi_q, hi_d;
  logic [15:0] frq_q, frq_d;
  logic        vld_q, vld_d;

  logic        rise, fall, snap, tmo, take;
  logic [31:0] cnt_p1;
  logic [32:0] trial, diff;

  always_comb begin
    level_d = level_q;
    if (in_wave >= TH_HIGH) level_d = 1'b1;
    else if (in_wave <= TH_LOW) level_d = 1'b0;
    rise   = ~level_q & level_d;
    fall   = level_q & ~level_d;
    cnt_p1 = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    cnt_d  = rise ? 32'd0 : cnt_p1;
    hcap_d = fall ? cnt_p1 : hcap_q;
    fell_d = rise ? 1'b0 : (fall | fell_q);
    snap   = rise & armed_q;
    tmo    = armed_q & ~rise & (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    take   = (state_q == S_IDLE) & pend_v_q & ~tmo;

    armed_d = rise | (armed_q & ~tmo);
    tmo_d   = rise ? 1'b0 : (tmo | tmo_q);

    // Single-entry pending slot: the newest snapshot always wins.
    pend_v_d = pend_v_q & ~take & ~tmo;
    pend_p_d = pend_p_q;
    pend_h_d = pend_h_q;
    if (snap) begin
      pend_v_d = 1'b1;
      pend_p_d = cnt_p1;
      pend_h_d = fell_q ? hcap_q : cnt_p1;
    end

    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    hact_d  = hact_q;
    disc_d  = disc_q | (tmo & (state_q != S_IDLE));
    per_d   = per_q;
    hi_d    = hi_q;
    frq_d   = frq_q;
    vld_d   = 1'b0;
    trial   = {rem_q, quo_q[31]};
    diff    = trial - {1'b0, div_q};

    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          div_d   = pend_p_q;
          hact_d  = pend_h_q;
          rem_d   = 32'd0;
          quo_d   = 32'(CLOCK_RATE);
          bit_d   = 5'd0;
          disc_d  = 1'b0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (!diff[32]) rem_d = diff[31:0];
        else           rem_d = trial[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!disc_q && !tmo) begin
          per_d = div_q;
          hi_d  = hact_q;
          frq_d = (quo_q > 32'd65535) ? 16'hFFFF : quo_q[15:0];
          vld_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo) begin
      per_d = 32'd0;
      hi_d  = 32'd0;
      frq_d = 16'd0;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q  <= S_IDLE;
      level_q  <= 1'b0;
      cnt_q    <= 32'd0;
      hcap_q   <= 32'd0;
      fell_q   <= 1'b0;
      armed_q  <= 1'b0;
      tmo_q    <= 1'b0;
      pend_v_q <= 1'b0;
      pend_p_q <= 32'd0;
      pend_h_q <= 32'd0;
      div_q    <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      bit_q    <= 5'd0;
      hact_q   <= 32'd0;
      disc_q   <= 1'b0;
      per_q    <= 32'd0;
      hi_q     <= 32'd0;
      frq_q    <= 16'd0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      fell_q   <= fell_d;
      armed_q  <= armed_d;
      tmo_q    <= tmo_d;
      pend_v_q <= pend_v_d;
      pend_p_q <= pend_p_d;
      pend_h_q <= pend_h_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bit_q    <= bit_d;
      hact_q   <= hact_d;
      disc_q   <= disc_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      frq_q    <= frq_d;
      vld_q    <= vld_d;
    end
  end

  assign period_cycles = per_q;
  assign high_cycles   = hi_q;
  assign freq_hz       = frq_q;
  assign valid         = vld_q;
  assign timeout       = tmo_q;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Directed bench for square_wave_period_meter
// (CLOCK_RATE=1e6, TIMEOUT_CYCLES=5000).
module tb_square_wave_period_meter;

  localparam logic signed [15:0] HI = 16'sd16384;
  localparam logic signed [15:0] LO = 16'sd0;

  logic               clk = 1'b0;
  logic               I_RSTn;
  logic signed [15:0] in_wave;
  logic [31:0]        period_cycles;
  logic [31:0]        high_cycles;
  logic [15:0]        freq_hz;
  logic               valid;
  logic               timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int vcnt   = 0;
  int nsat   = 0;
  int last_v = -1;
  int v0;
  bit sat_mode = 1'b0;

  square_wave_period_meter #(
    .CLOCK_RATE    (1000000),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .in_wave      (in_wave),
    .period_cycles(period_cycles),
    .high_cycles  (high_cycles),
    .freq_hz      (freq_hz),
    .valid        (valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      if (sat_mode) begin
        chk("sat_period", period_cycles, 32'd10);
        chk("sat_high", high_cycles, 32'd5);
        chk("sat_freq", {16'd0, freq_hz}, 32'd65535);
        if (last_v >= 0)
          chk("sat_gap", 32'(cyc - last_v >= 34), 32'd1);
        last_v = cyc;
        nsat++;
      end
    end
  end

  task automatic hold(input logic signed [15:0] v, input int n);
    in_wave = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo);
    hold(HI, hi);
    hold(LO, lo);
  endtask

  task automatic do_reset();
    I_RSTn  = 1'b0;
    in_wave = LO;
    repeat (3) @(posedge clk);
    #1;
    I_RSTn = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period_cycles, 32'd0);
    chk({tag, "_high"}, high_cycles, 32'd0);
    chk({tag, "_freq"}, {16'd0, freq_hz}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic chk_meas(input string tag, input int p, input int h,
                          input int f);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_period"}, period_cycles, 32'(p));
    chk({tag, "_high"}, high_cycles, 32'(h));
    chk({tag, "_freq"}, {16'd0, freq_hz}, 32'(f));
    chk({tag, "_tmo"}, {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    I_RSTn  = 1'b0;
    in_wave = LO;
    do_reset();
    chk_zero("rst");
    chk("rst_tmo", {31'd0, timeout}, 32'd0);

    // basic 1000/300 measurement
    v0 = vcnt;
    wave(300, 700);
    chk("t1_arm_only", 32'(vcnt - v0), 32'd0);
    hold(HI, 34);
    chk("t1_early", {31'd0, valid}, 32'd0);
    hold(HI, 1);
    chk_meas("t1", 1000, 300, 1000);
    hold(HI, 1);
    chk("t1_pulse", {31'd0, valid}, 32'd0);

    // hysteresis band
    do_reset();
    v0 = vcnt;
    repeat (4) begin
      hold(16'sd6000, 50);
      hold(16'sd10000, 50);
    end
    hold(16'sd12000, 100);
    repeat (2) begin
      hold(16'sd10000, 50);
      hold(16'sd6000, 50);
    end
    hold(LO, 100);
    chk("hy_none", 32'(vcnt - v0), 32'd0);
    hold(16'sd12000, 34);
    chk("hy_early", {31'd0, valid}, 32'd0);
    hold(16'sd12000, 1);
    chk_meas("hy", 400, 300, 2500);

    // period exactly TIMEOUT: edge beats timeout, then stop toggling
    do_reset();
    wave(100, 4900);
    hold(HI, 1);
    chk("eq_tmo", {31'd0, timeout}, 32'd0);
    chk("eq_valid", {31'd0, valid}, 32'd0);
    hold(HI, 34);
    chk_meas("eq", 5000, 100, 200);
    hold(HI, 4965);
    chk("to_pre", {31'd0, timeout}, 32'd0);
    v0 = vcnt;
    hold(HI, 1);
    chk("to_tmo", {31'd0, timeout}, 32'd1);
    chk("to_valid", {31'd0, valid}, 32'd1);
    chk("to_period", period_cycles, 32'd0);
    chk("to_high", high_cycles, 32'd0);
    chk("to_freq", {16'd0, freq_hz}, 32'd0);
    hold(LO, 1);
    chk("to_pulse", {31'd0, valid}, 32'd0);
    chk("to_count", 32'(vcnt - v0), 32'd1);
    hold(LO, 10);
    hold(HI, 1);
    chk("re_tmo", {31'd0, timeout}, 32'd0);
    chk("re_valid", {31'd0, valid}, 32'd0);
    hold(HI, 299);
    hold(LO, 700);
    hold(HI, 35);
    chk_meas("re", 1000, 300, 1000);

    // constant high after arming: only a timeout is reported
    do_reset();
    v0 = vcnt;
    hold(HI, 5000);
    chk("ch_pre", {31'd0, timeout}, 32'd0);
    hold(HI, 1);
    chk("ch_tmo", {31'd0, timeout}, 32'd1);
    chk("ch_valid", {31'd0, valid}, 32'd1);
    chk("ch_period", period_cycles, 32'd0);
    hold(HI, 1);
    chk("ch_count", 32'(vcnt - v0), 32'd1);

    // short period: decimated but consistent reports
    do_reset();
    sat_mode = 1'b1;
    repeat (40) wave(5, 5);
    hold(LO, 150);
    sat_mode = 1'b0;
    chk("sat_count", 32'(nsat >= 10), 32'd1);

    // reset in the middle of a division
    do_reset();
    wave(300, 700);
    wave(300, 700);
    hold(HI, 11);
    I_RSTn  = 1'b0;
    in_wave = LO;
    @(posedge clk);
    #1;
    I_RSTn = 1'b1;
    chk_zero("rd");
    chk("rd_tmo", {31'd0, timeout}, 32'd0);
    v0 = vcnt;
    hold(LO, 988);
    chk("rd_abort", 32'(vcnt - v0), 32'd0);
    wave(300, 700);
    chk("rd_rearm", 32'(vcnt - v0), 32'd0);
    hold(HI, 35);
    chk_meas("rd", 1000, 300, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
